// File: rtl/sample_reg_arbiter_pkg.sv
// Shared types and round-robin pick helper for the sample register arbiter.
// The pick function works on a fixed 16-wide request vector so any N in 2..16 can share it.
package sample_arb_pkg;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} arb_state_t;

  localparam int RR_MAX   = 16;
  localparam int RR_IDX_W = 4;
  localparam int RR_J_W   = RR_IDX_W + 1;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req scanning ptr, ptr+1, ... wrapping at n; requires ptr < n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   req,
                                       input logic [RR_IDX_W-1:0] ptr,
                                       input int                  n);
    rr_pick_t          r;
    logic [RR_J_W-1:0] j;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = 0; i < RR_MAX; i++) begin
      j = {1'b0, ptr} + RR_J_W'(i);
      j = (j >= RR_J_W'(n)) ? (j - RR_J_W'(n)) : j;
      if ((i < n) && !r.found && req[j[RR_IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = j[RR_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sample_reg_arbiter_rr_pointer.sv
// Round-robin pointer: combinational winner pick from the eligible set plus the
// registered pointer, which moves to one past the winner whenever a capture is taken.
module rr_pointer
  import sample_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          CLK,
  input  logic          CLR_N,
  input  logic [N-1:0]  i_req,
  input  logic          i_adv,
  output logic [SW-1:0] o_sel,
  output logic          o_found
);

  logic [RR_IDX_W-1:0] r_ptr;
  logic [RR_MAX-1:0]   w_req_ext;
  rr_pick_t            w_pick;
  logic                w_wrap;

  // Widen the request vector and evaluate the winner from the current pointer.
  always_comb begin
    w_req_ext        = '0;
    w_req_ext[N-1:0] = i_req;
    w_pick           = rr_pick(w_req_ext, r_ptr, N);
    w_wrap           = (w_pick.idx == RR_IDX_W'(N - 1));
  end

  assign o_sel   = w_pick.idx[SW-1:0];
  assign o_found = w_pick.found;

  // Pointer register: advances only on a taken capture.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= w_wrap ? RR_IDX_W'(0) : (w_pick.idx + RR_IDX_W'(1));
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/sample_reg_arbiter.sv
// Round-robin arbiter in front of a single S-bit holding register with a
// valid/ready output handshake; owns the register's load and clear sequencing.
module sample_reg_arbiter
  import sample_arb_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int S  = 12,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           CLK,
  input  logic           CLR_N,
  input  logic [N-1:0]   REQ,
  input  logic [N*S-1:0] DATA,
  output logic [N-1:0]   GNT,
  input  logic           FLUSH,
  output logic [S-1:0]   OUT_DATA,
  output logic [SW-1:0]  OUT_SRC,
  output logic           OUT_VALID,
  input  logic           OUT_READY,
  output logic           BUSY
);

  arb_state_t    r_state;
  logic [N-1:0]  w_elig;
  logic [N-1:0]  w_onehot;
  logic [SW-1:0] w_sel;
  logic          w_found;
  logic          w_capture;
  logic          w_consume;
  logic [S-1:0]  w_words [N];

  for (genvar g = 0; g < N; g++) begin : g_words
    assign w_words[g] = DATA[g*S +: S];
  end

  // The requester granted last cycle is still showing REQ, so it sits out one cycle.
  assign w_elig = REQ & ~GNT;

  rr_pointer #(.N(N)) u_rr_pointer (
    .CLK     (CLK),
    .CLR_N   (CLR_N),
    .i_req   (w_elig),
    .i_adv   (w_capture),
    .o_sel   (w_sel),
    .o_found (w_found)
  );

  // Capture / consume decisions; FLUSH suppresses both.
  always_comb begin
    w_capture = 1'b0;
    w_consume = 1'b0;
    if (FLUSH) begin
      w_capture = 1'b0;
      w_consume = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_capture = w_found;
        end
        HOLD: begin
          w_capture = OUT_READY & w_found;
          w_consume = OUT_READY & ~w_found;
        end
        default: begin
          w_capture = 1'b0;
          w_consume = 1'b0;
        end
      endcase
    end
  end

  // One-hot grant vector for the current winner.
  always_comb begin
    w_onehot        = '0;
    w_onehot[w_sel] = 1'b1;
  end

  // Holding register: async clear, sync clear on FLUSH, load on capture.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      OUT_DATA <= '0;
      OUT_SRC  <= '0;
    end else if (FLUSH) begin
      OUT_DATA <= '0;
      OUT_SRC  <= OUT_SRC;
    end else if (w_capture) begin
      OUT_DATA <= w_words[w_sel];
      OUT_SRC  <= w_sel;
    end else begin
      OUT_DATA <= OUT_DATA;
      OUT_SRC  <= OUT_SRC;
    end
  end

  // Handshake FSM with registered GNT, OUT_VALID and BUSY.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_state   <= IDLE;
      GNT       <= '0;
      OUT_VALID <= 1'b0;
      BUSY      <= 1'b0;
    end else if (FLUSH) begin
      r_state   <= IDLE;
      GNT       <= '0;
      OUT_VALID <= 1'b0;
      BUSY      <= 1'b0;
    end else if (w_capture) begin
      r_state   <= HOLD;
      GNT       <= w_onehot;
      OUT_VALID <= 1'b1;
      BUSY      <= 1'b1;
    end else if (w_consume) begin
      r_state   <= IDLE;
      GNT       <= '0;
      OUT_VALID <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      r_state   <= r_state;
      GNT       <= '0;
      OUT_VALID <= OUT_VALID;
      BUSY      <= BUSY;
    end
  end

endmodule

// File: tb/tb_sample_reg_arbiter.sv
// Scoreboard bench for sample_reg_arbiter: a behavioural model predicts the
// post-edge outputs, a negedge monitor compares them, plus directed scenario checks.
module tb_sample_reg_arbiter;

  localparam int N = 4;
  localparam int S = 12;

  logic           CLK = 1'b0;
  logic           CLR_N;
  logic [N-1:0]   REQ;
  logic [N*S-1:0] DATA;
  logic [N-1:0]   GNT;
  logic           FLUSH;
  logic [S-1:0]   OUT_DATA;
  logic [1:0]     OUT_SRC;
  logic           OUT_VALID;
  logic           OUT_READY;
  logic           BUSY;

  always #5 CLK = ~CLK;

  sample_reg_arbiter #(.N(N), .S(S)) dut (
    .CLK       (CLK),
    .CLR_N     (CLR_N),
    .REQ       (REQ),
    .DATA      (DATA),
    .GNT       (GNT),
    .FLUSH     (FLUSH),
    .OUT_DATA  (OUT_DATA),
    .OUT_SRC   (OUT_SRC),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .BUSY      (BUSY)
  );

  typedef struct packed {
    logic [N-1:0] gnt;
    logic         valid;
    logic         busy;
    logic [S-1:0] data;
    logic [1:0]   src;
  } snap_t;

  snap_t exp_q[$];
  snap_t mon_e;
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model state: who holds the register and whose turn it is.
  int         m_ptr;
  int         m_gnt;
  bit         m_full;
  logic [S-1:0] m_data;
  int         m_src;

  logic [N*S-1:0] rd;
  logic [3:0]     rr_exp [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*S-1:0] rand_data();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[N*S-1:0];
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_gnt  = -1;
    m_full = 1'b0;
    m_data = '0;
    m_src  = 0;
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic [N*S-1:0] data,
                            input logic rdy, input logic fl, output snap_t e);
    int win;
    win = -1;
    if (fl) begin
      m_full = 1'b0;
      m_data = '0;
      m_gnt  = -1;
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (win < 0 && req[i] && i != m_gnt) win = i;
      end
      if (win >= 0 && (!m_full || rdy)) begin
        m_full = 1'b1;
        m_data = data[win*S +: S];
        m_src  = win;
        m_gnt  = win;
        m_ptr  = (win + 1) % N;
      end else begin
        m_gnt = -1;
        if (m_full && rdy) m_full = 1'b0;
      end
    end
    e.gnt   = (m_gnt >= 0) ? (4'(1) << m_gnt) : 4'b0000;
    e.valid = m_full;
    e.busy  = m_full;
    e.data  = m_data;
    e.src   = m_src[1:0];
  endtask

  // Apply inputs between edges, predict, and queue the prediction at the edge.
  task automatic step(input logic [N-1:0] req, input logic [N*S-1:0] data,
                      input logic rdy, input logic fl);
    snap_t e;
    REQ       = req;
    DATA      = data;
    OUT_READY = rdy;
    FLUSH     = fl;
    model_step(req, data, rdy, fl, e);
    @(posedge CLK);
    exp_q.push_back(e);
    #1;
  endtask

  // Monitor: every cycle the DUT presents its registered outputs, compare to the model.
  initial begin
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("mon_gnt",   32'(GNT),       32'(mon_e.gnt));
        chk("mon_valid", 32'(OUT_VALID), 32'(mon_e.valid));
        chk("mon_busy",  32'(BUSY),      32'(mon_e.busy));
        chk("mon_data",  32'(OUT_DATA),  32'(mon_e.data));
        chk("mon_src",   32'(OUT_SRC),   32'(mon_e.src));
      end
    end
  end

  initial begin
    CLR_N = 1'b0; REQ = '0; DATA = '0; OUT_READY = 1'b0; FLUSH = 1'b0;
    model_reset();
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_gnt",   32'(GNT),       32'd0);
    chk("rst_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_busy",  32'(BUSY),      32'd0);
    chk("rst_data",  32'(OUT_DATA),  32'd0);
    chk("rst_src",   32'(OUT_SRC),   32'd0);
    @(negedge CLK); #1; CLR_N = 1'b1;

    // Single request then a long stall.
    step(4'b0010, {12'h000, 12'h000, 12'h5A5, 12'h000}, 1'b0, 1'b0);
    chk("single_gnt",   32'(GNT),       32'h2);
    chk("single_valid", 32'(OUT_VALID), 32'd1);
    chk("single_data",  32'(OUT_DATA),  32'h5A5);
    chk("single_src",   32'(OUT_SRC),   32'd1);
    step(4'b0000, rand_data(), 1'b0, 1'b0);
    chk("single_gnt_drop", 32'(GNT), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(4'b0000, rand_data(), 1'b0, 1'b0);
      chk("single_hold_data",  32'(OUT_DATA),  32'h5A5);
      chk("single_hold_valid", 32'(OUT_VALID), 32'd1);
    end

    // Asynchronous reset while holding 0xABC.
    step(4'b0000, rand_data(), 1'b0, 1'b1);
    step(4'b0001, {36'h0, 12'hABC}, 1'b0, 1'b0);
    chk("abc_loaded", 32'(OUT_DATA), 32'hABC);
    step(4'b0000, rand_data(), 1'b0, 1'b0);
    @(negedge CLK); #1;
    CLR_N = 1'b0;
    #1;
    chk("arst_data",  32'(OUT_DATA),  32'd0);
    chk("arst_valid", 32'(OUT_VALID), 32'd0);
    chk("arst_gnt",   32'(GNT),       32'd0);
    chk("arst_busy",  32'(BUSY),      32'd0);
    chk("arst_src",   32'(OUT_SRC),   32'd0);
    model_reset();
    @(posedge CLK); @(negedge CLK); #1; CLR_N = 1'b1;

    // Round robin from pointer 0 with everyone requesting.
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, rand_data(), 1'b1, 1'b0);
      chk("rr_gnt",   32'(GNT),       32'(rr_exp[i]));
      chk("rr_valid", 32'(OUT_VALID), 32'd1);
    end

    // A lone requester is masked in its grant cycle.
    step(4'b0000, rand_data(), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(4'b0100, rand_data(), 1'b1, 1'b0);
      chk("mask_gnt", 32'(GNT), (i % 2 == 0) ? 32'h4 : 32'h0);
    end

    // FLUSH beats a pending back-to-back capture.
    step(4'b0000, rand_data(), 1'b0, 1'b1);
    step(4'b0001, rand_data(), 1'b0, 1'b0);
    step(4'b0100, rand_data(), 1'b1, 1'b1);
    chk("flush_valid", 32'(OUT_VALID), 32'd0);
    chk("flush_data",  32'(OUT_DATA),  32'd0);
    chk("flush_gnt",   32'(GNT),       32'd0);
    chk("flush_busy",  32'(BUSY),      32'd0);
    step(4'b0100, rand_data(), 1'b1, 1'b0);
    chk("flush_regrant", 32'(GNT), 32'h4);

    // Request withdrawn during a stall never gets a grant.
    step(4'b0000, rand_data(), 1'b0, 1'b1);
    step(4'b0001, rand_data(), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(4'b1000, rand_data(), 1'b0, 1'b0);
      chk("wd_gnt", 32'(GNT), 32'd0);
    end
    step(4'b0000, rand_data(), 1'b0, 1'b0);
    step(4'b0000, rand_data(), 1'b1, 1'b0);
    chk("wd_valid", 32'(OUT_VALID), 32'd0);
    chk("wd_busy",  32'(BUSY),      32'd0);
    chk("wd_gnt_end", 32'(GNT),     32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rd = rand_data();
      step(4'($urandom_range(0, 15)), rd,
           (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0));
    end

    @(negedge CLK); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
